fre_range_ctrl: RTL and testbench
=================================

// Module: fre_range_ctrl
// PURPOSE
//  Measurement sequencer and auto-ranger for the frequency-meter counter datapath.
//  Each measurement runs clear -> gate -> latch on the slow gate clock, so one gate equals one clk_05 period.
//  Selects the low (kHz) or high (MHz) counting range from overflow and hysteresis.
//  Sits between the counters and the display scanner; it supplies the display word and the range LED.
// PARAMETERS
//  GATE_TICKS   1          gate-open length in clk_05 cycles (>=1)
//  DOWN_HYST    2          consecutive low HIGH-range readings before returning to LOW range (>=1)
//  DOWN_THRESH  24'h000100 BCD threshold; a HIGH-range reading below it counts toward DOWN_HYST
// PORTS
//  clk_05     in   1   gate/sequencer clock
//  Rst_n      in   1   reset, asynchronous, active-low
//  run        in   1   1 = measure continuously; 0 = park in IDLE after the current LATCH
//  cnt_data   in   24  BCD count from the selected counter, stable in LATCH
//  cnt_ovf    in   1   overflow flag from the selected counter, stable in LATCH
//  gate_en    out  1   counter gate enable
//  cnt_clr    out  1   counter synchronous clear
//  range_hi   out  1   0 = LOW range, 1 = HIGH range (counter mux select)
//  kilo_led   out  1   mirrors range_hi; drives the range LED
//  data_out   out  24  BCD display word
//  data_valid out  1   one-cycle pulse when data_out updates
//  over_rng   out  1   1 = HIGH range overflowed; data_out is saturated
// BEHAVIOUR
//  Reset (async): state=CLR, range_hi=0, kilo_led=0, data_out=0, over_rng=0, hyst_cnt=0.
//   gate_en=0, cnt_clr=0, data_valid=0 (all registered).
//  FSM, one transition per clk_05 rising edge:
//   IDLE : gate_en=0, cnt_clr=0. Goes to CLR when run=1.
//   CLR  : cnt_clr=1 for exactly 1 cycle. Goes to GATE.
//   GATE : gate_en=1 for GATE_TICKS cycles (tick counter). Goes to LATCH on the last tick.
//   LATCH: gate_en=0. Samples cnt_data/cnt_ovf and applies the decision table.
//          Next state is CLR if run=1, else IDLE.
//  Measurement period = GATE_TICKS+2 cycles. data_valid and data_out update on the LATCH exit edge.
//  Decision table at LATCH:
//   LOW & !ovf  : data_out=cnt_data, over_rng=0, data_valid=1.
//   LOW & ovf   : range_hi=1, kilo_led=1, hyst_cnt=0. Reading discarded; data_valid=0.
//   HIGH & ovf  : data_out=24'h999999, over_rng=1, data_valid=1. Stays HIGH.
//   HIGH & !ovf & cnt_data<DOWN_THRESH : data_out=cnt_data, over_rng=0, data_valid=1, hyst_cnt+1.
//       When hyst_cnt reaches DOWN_HYST: range_hi=0, kilo_led=0, hyst_cnt=0.
//   HIGH & !ovf & cnt_data>=DOWN_THRESH : data_out=cnt_data, over_rng=0, data_valid=1, hyst_cnt=0.
//  BCD compare is a plain 24-bit unsigned compare; BCD ordering preserves magnitude.
//  A range change takes effect from the next CLR, so the counter is always cleared after a switch.
//  run deasserted mid-GATE: the measurement completes; the FSM parks after LATCH.
//  Rst_n asserted mid-GATE: gate_en drops immediately and the partial count is never latched.
//  hyst_cnt saturates at DOWN_HYST; it is never wider than $clog2(DOWN_HYST+1).
// CONFIGURATION
//  FRE_HOLD_EN defined:
//   - adds input hold (1 bit).
//   - While hold=1, LATCH skips the data_out, over_rng and data_valid updates.
//   - Ranging, hyst_cnt and the FSM continue unchanged.
//  FRE_HOLD_EN undefined: no hold port; data_out updates every valid LATCH.
// STRUCTURE
//  fre_pkg: state encodings (IDLE/CLR/GATE/LATCH), SAT_BCD=24'h999999, range constants LOW/HIGH.
//  Sub-module fre_hyst_cnt: saturating down-range hysteresis counter.
//   - inputs inc, clr; output reached.
//  Everything else is flat in fre_range_ctrl.
// TESTING
//  1. Reset, run=1, GATE_TICKS=1 -> cnt_clr pulses every 3rd cycle; gate_en high 1 of 3 cycles.
//  2. LOW range, cnt_data=24'h012345, ovf=0 -> data_out=24'h012345, data_valid=1 for 1 cycle, range_hi=0.
//  3. LOW, ovf=1 -> range_hi=1 and kilo_led=1 at the next LATCH exit, data_out unchanged.
//     Next meas. 24'h000050 ->
//       - data_out=24'h000050.
//       - Second consecutive <24'h000100 reading -> range_hi=0.
//  4. HIGH, ovf=1 -> data_out=24'h999999, over_rng=1; following reading 24'h000200 clears over_rng.
//     HIGH readings 24'h000050, 24'h000300, 24'h000050 -> range_hi stays 1 (hysteresis reset).
//  5. run=0 during GATE -> one LATCH, then IDLE with gate_en=0.
//     Rst_n pulse mid-GATE -> all outputs at reset values immediately.
//  6. FRE_HOLD_EN, hold=1 -> data_out frozen at its last value; an ovf in LOW still sets range_hi=1.

Source files
------------

// File: rtl/fre_pkg.sv
// Shared definitions for the frequency-meter range controller:
// sequencer state encodings, the saturated display word and range codes.
package fre_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } fre_state_t;

    // Display word shown when the HIGH range overflows.
    localparam logic [23:0] SAT_BCD = 24'h999999;

    // Range codes, also the counter mux select.
    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

// File: rtl/fre_hyst_cnt.sv
// Down-range hysteresis counter. Counts consecutive low HIGH-range readings.
// 'reached' is high when the next inc completes DOWN_HYST readings; that inc
// also returns the count to zero because the range is about to switch back.
// The counter never holds more than DOWN_HYST, so $clog2(DOWN_HYST+1) bits suffice.
module fre_hyst_cnt
#(
    parameter int DOWN_HYST = 2
)
(
    input  logic clk_05,
    input  logic Rst_n,
    input  logic inc,
    input  logic clr,
    output logic reached
);

    localparam int CW = $clog2(DOWN_HYST + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reached does not depend on inc, so no combinational path back to the caller.
    assign reached = (cnt_q >= CW'(DOWN_HYST - 1));

    // Next count: clear wins, an inc that completes the run wraps to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (reached) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_05 or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fre_range_ctrl.sv
// Measurement sequencer and auto-ranger for the frequency-meter counters.
// Runs CLR -> GATE -> LATCH on clk_05 and picks the LOW/HIGH counting range
// from overflow and down-range hysteresis.
// Optional feature: define FRE_HOLD_EN to add a 'hold' input that freezes the
// display word while ranging keeps running.
//
// Handshake: data_valid is a one-cycle strobe with no ready; data_out holds
// its value until the next strobe and is valid whenever sampled.
module fre_range_ctrl
    import fre_pkg::*;
#(
    parameter int          GATE_TICKS  = 1,
    parameter int          DOWN_HYST   = 2,
    parameter logic [23:0] DOWN_THRESH = 24'h000100
)
(
    input  logic        clk_05,
    input  logic        Rst_n,
    input  logic        run,
    input  logic [23:0] cnt_data,
    input  logic        cnt_ovf,
`ifdef FRE_HOLD_EN
    input  logic        hold,
`endif
    output logic        gate_en,
    output logic        cnt_clr,
    output logic        range_hi,
    output logic        kilo_led,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        over_rng,
    output logic [1:0]  dbg_state_o
);

    localparam int TICK_W = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;

    fre_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              gate_en_q, cnt_clr_q;
    logic              range_hi_q, range_hi_d;
    logic [23:0]       data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              over_rng_q, over_rng_d;
    logic              hyst_inc, hyst_clr, hyst_reached;
    logic              hold_w;
    logic              below_thresh;

`ifdef FRE_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // BCD digit order preserves magnitude, so a binary compare is enough.
    assign below_thresh = (cnt_data < DOWN_THRESH);

    // Next-state logic for the measurement sequencer and the gate tick counter.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = GATE;
                tick_d  = '0;
            end
            GATE: begin
                if (tick_q == TICK_W'(GATE_TICKS - 1)) begin
                    state_d = LATCH;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            LATCH: begin
                state_d = run ? CLR : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Range/display decision table, applied only when leaving LATCH.
    // An overflow in HIGH leaves the hysteresis count where it was.
    always_comb begin
        range_hi_d   = range_hi_q;
        data_out_d   = data_out_q;
        over_rng_d   = over_rng_q;
        data_valid_d = 1'b0;
        hyst_inc     = 1'b0;
        hyst_clr     = 1'b0;
        if (state_q == LATCH) begin
            if (range_hi_q == LOW) begin
                if (cnt_ovf) begin
                    range_hi_d = HIGH;
                    hyst_clr   = 1'b1;
                end else if (!hold_w) begin
                    data_out_d   = cnt_data;
                    over_rng_d   = 1'b0;
                    data_valid_d = 1'b1;
                end
            end else begin
                if (cnt_ovf) begin
                    if (!hold_w) begin
                        data_out_d   = SAT_BCD;
                        over_rng_d   = 1'b1;
                        data_valid_d = 1'b1;
                    end
                end else begin
                    if (!hold_w) begin
                        data_out_d   = cnt_data;
                        over_rng_d   = 1'b0;
                        data_valid_d = 1'b1;
                    end
                    if (below_thresh) begin
                        hyst_inc = 1'b1;
                        if (hyst_reached) begin
                            range_hi_d = LOW;
                        end
                    end else begin
                        hyst_clr = 1'b1;
                    end
                end
            end
        end
    end

    fre_hyst_cnt #(
        .DOWN_HYST (DOWN_HYST)
    ) u_hyst (
        .clk_05  (clk_05),
        .Rst_n   (Rst_n),
        .inc     (hyst_inc),
        .clr     (hyst_clr),
        .reached (hyst_reached)
    );

    // Sequencer state and tick registers; reset parks in CLR.
    always_ff @(posedge clk_05 or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= CLR;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // Registered outputs; strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk_05 or negedge Rst_n) begin
        if (!Rst_n) begin
            gate_en_q    <= 1'b0;
            cnt_clr_q    <= 1'b0;
            range_hi_q   <= LOW;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            over_rng_q   <= 1'b0;
        end else begin
            gate_en_q    <= (state_d == GATE);
            cnt_clr_q    <= (state_d == CLR);
            range_hi_q   <= range_hi_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            over_rng_q   <= over_rng_d;
        end
    end

    assign gate_en     = gate_en_q;
    assign cnt_clr     = cnt_clr_q;
    assign range_hi    = range_hi_q;
    assign kilo_led    = range_hi_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign over_rng    = over_rng_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fre_range_ctrl.sv
// Bench for fre_range_ctrl: directed scenarios followed by random readings,
// checked against a per-measurement model of the ranging rules.
module tb_fre_range_ctrl;

    localparam int          GT = 1;
    localparam int          DH = 2;
    localparam logic [23:0] TH = 24'h000100;
    localparam int          P  = GT + 2;

    logic        clk_05 = 1'b0;
    logic        Rst_n  = 1'b1;
    logic        run    = 1'b0;
    logic [23:0] cnt_data = '0;
    logic        cnt_ovf  = 1'b0;
`ifdef FRE_HOLD_EN
    logic        hold = 1'b0;
`endif
    logic        gate_en, cnt_clr, range_hi, kilo_led, data_valid, over_rng;
    logic [23:0] data_out;
    logic [1:0]  dbg_state_o;

    int errors = 0;
    int checks = 0;

    // model state
    logic        m_range;
    int          m_hyst;
    logic [23:0] m_data;
    logic        m_over;
    logic [23:0] exp_q[$];

    fre_range_ctrl #(
        .GATE_TICKS  (GT),
        .DOWN_HYST   (DH),
        .DOWN_THRESH (TH)
    ) dut (
        .clk_05      (clk_05),
        .Rst_n       (Rst_n),
        .run         (run),
        .cnt_data    (cnt_data),
        .cnt_ovf     (cnt_ovf),
`ifdef FRE_HOLD_EN
        .hold        (hold),
`endif
        .gate_en     (gate_en),
        .cnt_clr     (cnt_clr),
        .range_hi    (range_hi),
        .kilo_led    (kilo_led),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .over_rng    (over_rng),
        .dbg_state_o (dbg_state_o)
    );

    // clock
    always #5 clk_05 = ~clk_05;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One measurement's effect, written straight from the decision table.
    task automatic model_latch(input logic [23:0] d, input logic o, output bit valid);
        bit h;
`ifdef FRE_HOLD_EN
        h = hold;
`else
        h = 1'b0;
`endif
        valid = 1'b0;
        if (!m_range) begin
            if (o) begin
                m_range = 1'b1;
                m_hyst  = 0;
            end else if (!h) begin
                m_data = d; m_over = 1'b0; valid = 1'b1;
            end
        end else if (o) begin
            if (!h) begin
                m_data = 24'h999999; m_over = 1'b1; valid = 1'b1;
            end
        end else begin
            if (!h) begin
                m_data = d; m_over = 1'b0; valid = 1'b1;
            end
            if (d < TH) begin
                m_hyst++;
                if (m_hyst >= DH) begin
                    m_range = 1'b0;
                    m_hyst  = 0;
                end
            end else begin
                m_hyst = 0;
            end
        end
        if (valid) exp_q.push_back(m_data);
    endtask

    // Async reset: outputs must be at reset values right away; release on a falling edge.
    task automatic do_reset(input string tag);
        Rst_n = 1'b0;
        #1;
        check({tag, "_gate_en"},    gate_en,    0);
        check({tag, "_cnt_clr"},    cnt_clr,    0);
        check({tag, "_range_hi"},   range_hi,   0);
        check({tag, "_kilo_led"},   kilo_led,   0);
        check({tag, "_data_out"},   data_out,   0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_over_rng"},   over_rng,   0);
        m_range = 1'b0; m_hyst = 0; m_data = '0; m_over = 1'b0;
        exp_q.delete();
        @(negedge clk_05);
        Rst_n = 1'b1;
    endtask

    // Drive one reading for a full CLR..LATCH period and check every cycle.
    task automatic meas(input logic [23:0] d, input logic o, input bit stop);
        bit          exp_valid;
        logic [23:0] w;
        cnt_data = d;
        cnt_ovf  = o;
        for (int j = 1; j <= P; j++) begin
            @(posedge clk_05);
            #1;
            if (j == P) begin
                model_latch(d, o, exp_valid);
                check("valid_pulse", data_valid, exp_valid);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("sb_data_out", data_out, w);
                end
                check("data_hold", data_out, m_data);
                check("over_rng", over_rng, m_over);
                check("range_hi", range_hi, m_range);
                check("kilo_led", kilo_led, m_range);
                check("gate_off_latch", gate_en, 0);
                check("clr_after_latch", cnt_clr, run);
            end else begin
                check("gate_en", gate_en, (j <= GT));
                check("cnt_clr_mid", cnt_clr, 0);
                check("valid_mid", data_valid, 0);
                check("range_mid", range_hi, m_range);
                if (stop && j == 1) run = 1'b0;
            end
        end
    endtask

    // Parked in IDLE for n cycles, then restart and see the CLR pulse.
    task automatic idle_resume(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_05);
            #1;
            check("idle_gate", gate_en, 0);
            check("idle_clr", cnt_clr, 0);
            check("idle_valid", data_valid, 0);
        end
        run = 1'b1;
        @(posedge clk_05);
        #1;
        check("resume_clr", cnt_clr, 1);
        check("resume_gate", gate_en, 0);
    endtask

    function automatic logic [23:0] rand_bcd(input int ndig);
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < ndig; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        logic [23:0] edge_vals[4];
        logic [23:0] d;
        edge_vals[0] = 24'h000099;
        edge_vals[1] = 24'h000100;
        edge_vals[2] = 24'h000000;
        edge_vals[3] = 24'h999999;

        #2;
        run = 1'b1;
        do_reset("reset");

        // cadence and LOW readings
        meas(24'h012345, 1'b0, 1'b0);
        meas(24'h000888, 1'b0, 1'b0);
        // LOW overflow -> HIGH, then two low readings -> back to LOW
        meas(24'h123456, 1'b1, 1'b0);
        meas(24'h000050, 1'b0, 1'b0);
        meas(24'h000050, 1'b0, 1'b0);
        // HIGH overflow saturates; a normal reading clears over_rng
        meas(24'h555555, 1'b1, 1'b0);
        meas(24'h000000, 1'b1, 1'b0);
        meas(24'h000200, 1'b0, 1'b0);
        // hysteresis reset by an in-between high reading
        meas(24'h000050, 1'b0, 1'b0);
        meas(24'h000300, 1'b0, 1'b0);
        meas(24'h000050, 1'b0, 1'b0);
        // threshold boundary: 0x100 is not below
        meas(24'h000100, 1'b0, 1'b0);
        meas(24'h000099, 1'b0, 1'b0);
        meas(24'h000099, 1'b0, 1'b0);
        // run dropped mid-GATE: one LATCH then IDLE
        meas(24'h000777, 1'b0, 1'b1);
        idle_resume(3);
        meas(24'h000321, 1'b0, 1'b0);
        // reset mid-GATE while in HIGH range with a saturated display
        meas(24'h000001, 1'b1, 1'b0);
        meas(24'h000001, 1'b1, 1'b0);
        cnt_data = 24'h000042;
        @(posedge clk_05);
        #1;
        check("pre_reset_gate", gate_en, 1);
        do_reset("midgate");
        meas(24'h000042, 1'b0, 1'b0);

`ifdef FRE_HOLD_EN
        hold = 1'b1;
        meas(24'h000111, 1'b0, 1'b0);
        meas(24'h000222, 1'b1, 1'b0);
        meas(24'h000010, 1'b0, 1'b0);
        hold = 1'b0;
        meas(24'h000010, 1'b0, 1'b0);
`endif

        // random readings
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       d = rand_bcd(2);
                1:       d = rand_bcd(3);
                2:       d = rand_bcd(6);
                default: d = edge_vals[$urandom_range(0, 3)];
            endcase
            if ($urandom_range(0, 9) == 0) begin
                meas(d, ($urandom_range(0, 3) == 0), 1'b1);
                idle_resume($urandom_range(1, 3));
            end else begin
                meas(d, ($urandom_range(0, 3) == 0), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
